// File: rtl/tilelink_pkg.sv
// Shared TileLink A-channel definitions: opcodes, arbiter states, beat math.
package tilelink_pkg;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] ArithmeticData = 3'd2;
  localparam logic [2:0] LogicalData    = 3'd3;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] Intent         = 3'd5;
  localparam logic [2:0] AcquireBlock   = 3'd6;  // not expected on this port

  // Largest size honoured when counting beats (4 KiB message).
  localparam int unsigned MAX_LG_SIZE = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BURST = 2'd2
  } arb_state_e;

  // Only Put and Atomic messages carry a data payload.
  function automatic logic has_data(input logic [2:0] opcode);
    return (opcode == PutFullData)    || (opcode == PutPartialData) ||
           (opcode == ArithmeticData) || (opcode == LogicalData);
  endfunction

  // Beats for a data message of 2^size bytes on a dw-bit bus.
  function automatic logic [12:0] beats_for(input int unsigned size,
                                            input int unsigned dw);
    int unsigned s;
    int unsigned lg;
    s  = (size > MAX_LG_SIZE) ? MAX_LG_SIZE : size;
    lg = $clog2(dw / 8);
    if (s > lg) return 13'(1 << (s - lg));
    return 13'd1;
  endfunction

endpackage

// File: rtl/tilelink_a_arbiter_rr_pick.sv
// Combinational round-robin picker: first set valid at or after i_ptr, wrapping.
module rr_pick #(
  parameter int M = 2
) (
  input  logic [M-1:0]         i_valid,
  input  logic [$clog2(M)-1:0] i_ptr,
  output logic [$clog2(M)-1:0] o_idx,
  output logic                 o_found
);
  localparam int IW = $clog2(M);

  // Scan from farthest to nearest so the closest valid to the pointer wins.
  always_comb begin
    int j;
    j       = 0;
    o_idx   = i_ptr;
    o_found = 1'b0;
    for (int k = M - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % M;
      if (i_valid[j]) begin
        o_idx   = IW'(j);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tilelink_a_arbiter.sv
// M-to-1 TileLink A-channel arbiter: round-robin, grant held through stalls
// and locked across multi-beat data messages; zero-latency forwarding.
module tilelink_a_arbiter
  import tilelink_pkg::*;
#(
  parameter int M     = 2,
  parameter int TL_DW = 32,
  parameter int TL_AW = 32,
  parameter int TL_RS = 4,
  parameter int TL_SZ = 4
) (
  input  logic                          tilelink_clock_i,
  input  logic                          tilelink_reset_i,
  input  logic [3*M-1:0]                master_a_opcode,
  input  logic [3*M-1:0]                master_a_param,
  input  logic [TL_SZ*M-1:0]            master_a_size,
  input  logic [TL_RS*M-1:0]            master_a_source,
  input  logic [TL_AW*M-1:0]            master_a_address,
  input  logic [(TL_DW/8)*M-1:0]        master_a_mask,
  input  logic [TL_DW*M-1:0]            master_a_data,
  input  logic [M-1:0]                  master_a_corrupt,
  input  logic [M-1:0]                  master_a_valid,
  output logic [M-1:0]                  master_a_ready,
  output logic [2:0]                    slave_a_opcode,
  output logic [2:0]                    slave_a_param,
  output logic [TL_SZ-1:0]              slave_a_size,
  output logic [$clog2(M)+TL_RS-1:0]    slave_a_source,
  output logic [TL_AW-1:0]              slave_a_address,
  output logic [TL_DW/8-1:0]            slave_a_mask,
  output logic [TL_DW-1:0]              slave_a_data,
  output logic                          slave_a_corrupt,
  output logic                          slave_a_valid,
  input  logic                          slave_a_ready,
  output logic [M-1:0]                  arb_grant_o
);
  localparam int IW = $clog2(M);
  localparam int MW = TL_DW / 8;

  arb_state_e     r_state;
  logic [IW-1:0]  r_gidx;
  logic [IW-1:0]  r_rr_ptr;
  logic [12:0]    r_beats_left;

  logic [2:0]       w_op   [M];
  logic [2:0]       w_par  [M];
  logic [TL_SZ-1:0] w_size [M];
  logic [TL_RS-1:0] w_src  [M];
  logic [TL_AW-1:0] w_addr [M];
  logic [MW-1:0]    w_mask [M];
  logic [TL_DW-1:0] w_data [M];

  logic [IW-1:0] w_pick;
  logic          w_found;
  logic [IW-1:0] w_sel;
  logic          w_has_grant;
  logic [M-1:0]  w_grant;
  logic          w_fire;
  logic [12:0]   w_beats;
  logic [IW-1:0] w_next_ptr;

  // Unflatten the per-master buses so the granted one can be indexed.
  for (genvar g = 0; g < M; g++) begin : g_slice
    assign w_op[g]   = master_a_opcode [3*g     +: 3];
    assign w_par[g]  = master_a_param  [3*g     +: 3];
    assign w_size[g] = master_a_size   [TL_SZ*g +: TL_SZ];
    assign w_src[g]  = master_a_source [TL_RS*g +: TL_RS];
    assign w_addr[g] = master_a_address[TL_AW*g +: TL_AW];
    assign w_mask[g] = master_a_mask   [MW*g    +: MW];
    assign w_data[g] = master_a_data   [TL_DW*g +: TL_DW];
  end

  rr_pick #(.M(M)) u_pick (
    .i_valid (master_a_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  // Outside IDLE the grant is frozen on r_gidx, even across valid gaps.
  assign w_sel       = (r_state == ST_IDLE) ? w_pick : r_gidx;
  assign w_has_grant = (r_state != ST_IDLE) || w_found;

  // One-hot grant, forced off while reset is held.
  always_comb begin
    w_grant = '0;
    if (!tilelink_reset_i && w_has_grant) w_grant[w_sel] = 1'b1;
  end

  assign arb_grant_o     = w_grant;
  assign slave_a_valid   = |(w_grant & master_a_valid);
  assign master_a_ready  = slave_a_ready ? w_grant : '0;
  assign slave_a_opcode  = w_op[w_sel];
  assign slave_a_param   = w_par[w_sel];
  assign slave_a_size    = w_size[w_sel];
  assign slave_a_source  = {w_sel, w_src[w_sel]};
  assign slave_a_address = w_addr[w_sel];
  assign slave_a_mask    = w_mask[w_sel];
  assign slave_a_data    = w_data[w_sel];
  assign slave_a_corrupt = master_a_corrupt[w_sel];

  assign w_fire     = slave_a_valid & slave_a_ready;
  assign w_beats    = has_data(slave_a_opcode) ? beats_for(32'(slave_a_size), TL_DW)
                                               : 13'd1;
  assign w_next_ptr = (w_sel == IW'(M - 1)) ? '0 : w_sel + 1'b1;

  // Grant FSM: pick in IDLE, hold a stalled first beat, lock multi-beat messages.
  always_ff @(posedge tilelink_clock_i) begin
    if (tilelink_reset_i) begin
      r_state      <= ST_IDLE;
      r_gidx       <= '0;
      r_rr_ptr     <= '0;
      r_beats_left <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_fire) begin
            if (w_beats == 13'd1) begin
              r_state  <= ST_IDLE;
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_state      <= ST_BURST;
              r_gidx       <= w_sel;
              r_beats_left <= w_beats - 13'd1;
            end
          end else if (r_state == ST_IDLE && w_found) begin
            r_state <= ST_HOLD;
            r_gidx  <= w_pick;
          end
        end
        ST_BURST: begin
          if (w_fire) begin
            r_beats_left <= r_beats_left - 13'd1;
            if (r_beats_left == 13'd1) begin
              r_state  <= ST_IDLE;
              r_rr_ptr <= w_next_ptr;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tilelink_a_arbiter.sv
// Bench for tilelink_a_arbiter: message-level reference model checked every
// cycle, plus literal fire-order expectations for each directed scenario.
module tb_tilelink_a_arbiter;
  localparam int M = 2, TL_DW = 32, TL_AW = 32, TL_RS = 4, TL_SZ = 4;
  localparam int MW = TL_DW / 8, IW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       t_op[M], t_par[M];
  logic [TL_SZ-1:0] t_size[M];
  logic [TL_RS-1:0] t_src[M];
  logic [TL_AW-1:0] t_addr[M];
  logic [MW-1:0]    t_mask[M];
  logic [TL_DW-1:0] t_data[M];
  logic [M-1:0]     t_cor;
  logic [M-1:0]     t_valid;
  logic             s_ready;

  logic [3*M-1:0]     f_op, f_par;
  logic [TL_SZ*M-1:0] f_size;
  logic [TL_RS*M-1:0] f_src;
  logic [TL_AW*M-1:0] f_addr;
  logic [MW*M-1:0]    f_mask;
  logic [TL_DW*M-1:0] f_data;

  logic [M-1:0]          master_a_ready, arb_grant_o;
  logic [2:0]            slave_a_opcode, slave_a_param;
  logic [TL_SZ-1:0]      slave_a_size;
  logic [IW+TL_RS-1:0]   slave_a_source;
  logic [TL_AW-1:0]      slave_a_address;
  logic [MW-1:0]         slave_a_mask;
  logic [TL_DW-1:0]      slave_a_data;
  logic                  slave_a_corrupt, slave_a_valid;

  always_comb begin
    f_op = '0; f_par = '0; f_size = '0; f_src = '0;
    f_addr = '0; f_mask = '0; f_data = '0;
    for (int i = 0; i < M; i++) begin
      f_op[3*i +: 3]           = t_op[i];
      f_par[3*i +: 3]          = t_par[i];
      f_size[TL_SZ*i +: TL_SZ] = t_size[i];
      f_src[TL_RS*i +: TL_RS]  = t_src[i];
      f_addr[TL_AW*i +: TL_AW] = t_addr[i];
      f_mask[MW*i +: MW]       = t_mask[i];
      f_data[TL_DW*i +: TL_DW] = t_data[i];
    end
  end

  tilelink_a_arbiter #(.M(M), .TL_DW(TL_DW), .TL_AW(TL_AW), .TL_RS(TL_RS), .TL_SZ(TL_SZ)) dut (
    .tilelink_clock_i (clk),
    .tilelink_reset_i (rst),
    .master_a_opcode  (f_op),
    .master_a_param   (f_par),
    .master_a_size    (f_size),
    .master_a_source  (f_src),
    .master_a_address (f_addr),
    .master_a_mask    (f_mask),
    .master_a_data    (f_data),
    .master_a_corrupt (t_cor),
    .master_a_valid   (t_valid),
    .master_a_ready   (master_a_ready),
    .slave_a_opcode   (slave_a_opcode),
    .slave_a_param    (slave_a_param),
    .slave_a_size     (slave_a_size),
    .slave_a_source   (slave_a_source),
    .slave_a_address  (slave_a_address),
    .slave_a_mask     (slave_a_mask),
    .slave_a_data     (slave_a_data),
    .slave_a_corrupt  (slave_a_corrupt),
    .slave_a_valid    (slave_a_valid),
    .slave_a_ready    (s_ready),
    .arb_grant_o      (arb_grant_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fire_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Fire order packed one nibble per fire as (master index + 1).
  function automatic logic [63:0] log_code();
    logic [63:0] c;
    c = 0;
    foreach (fire_log[i]) c = (c << 4) | 64'(fire_log[i] + 1);
    return c;
  endfunction

  // Reference model at message level: owner (-1 when free), beats still owed
  // by the owner's current message (0 = first beat not yet taken), rr pointer.
  int m_owner = -1;
  int m_left  = 0;
  int m_rr    = 0;

  always @(negedge clk) begin
    int g, s, beats, n_owner, n_left, n_rr;
    bit ev, fire;
    logic [M-1:0] eg, er;
    g = -1;
    if (m_owner >= 0) g = m_owner;
    else
      for (int k = 0; k < M; k++)
        if (g < 0 && t_valid[(m_rr + k) % M]) g = (m_rr + k) % M;
    eg = '0; ev = 1'b0;
    if (!rst && g >= 0) begin eg[g] = 1'b1; ev = t_valid[g]; end
    er = s_ready ? eg : '0;
    chk("grant", 64'(arb_grant_o), 64'(eg));
    chk("slave_valid", 64'(slave_a_valid), 64'(ev));
    chk("master_ready", 64'(master_a_ready), 64'(er));
    if (ev) begin
      chk("opcode",  64'(slave_a_opcode),  64'(t_op[g]));
      chk("param",   64'(slave_a_param),   64'(t_par[g]));
      chk("size",    64'(slave_a_size),    64'(t_size[g]));
      chk("source",  64'(slave_a_source),  64'((g << TL_RS) | int'(t_src[g])));
      chk("address", 64'(slave_a_address), 64'(t_addr[g]));
      chk("mask",    64'(slave_a_mask),    64'(t_mask[g]));
      chk("data",    64'(slave_a_data),    64'(t_data[g]));
      chk("corrupt", 64'(slave_a_corrupt), 64'(t_cor[g]));
    end
    fire = ev && s_ready;
    if (fire) fire_log.push_back(g);
    n_owner = m_owner; n_left = m_left; n_rr = m_rr;
    if (rst) begin
      n_owner = -1; n_left = 0; n_rr = 0;
    end else if (fire) begin
      if (m_left == 0) begin
        s = (t_size[g] > 12) ? 12 : int'(t_size[g]);
        beats = (t_op[g] < 4 && (1 << s) > MW) ? (1 << s) / MW : 1;
        n_left = beats - 1;
      end else n_left = m_left - 1;
      if (n_left == 0) begin n_owner = -1; n_rr = (g + 1) % M; end
      else n_owner = g;
    end else if (m_owner < 0 && g >= 0) n_owner = g;
    m_owner <= n_owner; m_left <= n_left; m_rr <= n_rr;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input int i, input bit v, input int op, input int size);
    t_valid[i] = v;
    t_op[i]    = 3'(op);
    t_par[i]   = 3'(i + 1);
    t_size[i]  = TL_SZ'(size);
    t_src[i]   = TL_RS'(op + size + 5 * i);
    t_addr[i]  = 32'h1000 * (i + 1) + 32'(size);
    t_mask[i]  = 4'hF ^ MW'(i);
    t_data[i]  = 32'hA500_0000 | 32'(i << 16) | 32'(op << 8) | 32'(size);
    t_cor[i]   = (i == 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
  end

  initial begin
    s_ready = 1'b1;
    drive(0, 1, 4, 2);
    drive(1, 1, 4, 2);
    tick(1);
    @(negedge clk);
    chk("reset_grant", 64'(arb_grant_o), 0);
    chk("reset_valid", 64'(slave_a_valid), 0);
    chk("reset_ready", 64'(master_a_ready), 0);
    tick(1);
    rst = 1'b0;

    // Both masters stream single-beat Gets: strict alternation.
    fire_log.delete();
    tick(4);
    drive(0, 0, 4, 2); drive(1, 0, 4, 2);
    chk("alt_order", log_code(), 64'h1212);

    // 4-beat PutFullData on master 0 locks out master 1's Get.
    fire_log.delete();
    drive(0, 1, 0, 4); drive(1, 1, 4, 2);
    tick(4);
    drive(0, 0, 0, 4);
    tick(1);
    drive(1, 0, 4, 2);
    tick(1);
    chk("burst4_order", log_code(), 64'h11112);

    // Stalled master 1 keeps its grant when master 0 shows up later.
    fire_log.delete();
    s_ready = 1'b0;
    drive(1, 1, 4, 3);
    tick(2);
    drive(0, 1, 1, 2);
    tick(2);
    @(negedge clk);
    chk("stall_grant", 64'(arb_grant_o), 64'h2);
    chk("stall_ready", 64'(master_a_ready), 0);
    tick(1);
    s_ready = 1'b1;
    tick(1);
    drive(1, 0, 4, 3);
    tick(1);
    drive(0, 0, 1, 2);
    tick(1);
    chk("stall_order", log_code(), 64'h21);

    // 8-beat Put with a two-cycle valid gap: lock survives the gap.
    fire_log.delete();
    drive(0, 1, 0, 5);
    tick(1);
    drive(1, 1, 4, 2);
    tick(1);
    drive(0, 0, 0, 5);
    @(negedge clk);
    chk("gap_grant", 64'(arb_grant_o), 64'h1);
    chk("gap_valid", 64'(slave_a_valid), 0);
    tick(2);
    drive(0, 1, 0, 5);
    tick(6);
    drive(0, 0, 0, 5);
    tick(1);
    drive(1, 0, 4, 2);
    tick(1);
    chk("burst8_order", log_code(), 64'h1_1111_1112);

    // Reset in the middle of a 4-beat burst abandons it and restarts at rr=0.
    fire_log.delete();
    drive(0, 1, 4, 2);
    tick(1);
    drive(0, 1, 4, 2); drive(1, 1, 0, 4);
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_grant", 64'(arb_grant_o), 0);
    chk("midrst_valid", 64'(slave_a_valid), 0);
    chk("midrst_ready", 64'(master_a_ready), 0);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_grant", 64'(arb_grant_o), 64'h1);
    tick(1);
    drive(0, 0, 4, 2);
    tick(4);
    drive(1, 0, 0, 4);
    tick(1);
    chk("reset_order", log_code(), 64'h1221_2222);

    // Large Get is still one beat: no lock, pointer moves on at once.
    fire_log.delete();
    drive(0, 1, 4, 6);
    tick(1);
    drive(0, 1, 4, 2); drive(1, 1, 4, 2);
    tick(1);
    drive(1, 0, 4, 2);
    tick(1);
    drive(0, 0, 4, 2);
    tick(1);
    chk("get6_order", log_code(), 64'h121);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
